// File: rtl/bcd_display_scanner_pkg.sv
// bcd_disp_pkg: shared digit count, active-high segment patterns and digit index type
package bcd_disp_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_OFF = 7'h00;
  typedef logic [1:0] digit_idx_t;
endpackage

// File: rtl/bcd_display_scanner_if.sv
// bcd_display_scanner_if: counter-side inputs and display pins of the scanner
interface bcd_display_scanner_if;
  logic [15:0] value_i;
  logic        of_i;
  logic        uf_i;
  logic        flag_ack_i;
  logic        en_i;
  logic        blank_lz_i;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  modport master (output value_i, of_i, uf_i, flag_ack_i, en_i, blank_lz_i, input an_o, seg_o, dp_o);
  modport slave  (input value_i, of_i, uf_i, flag_ack_i, en_i, blank_lz_i, output an_o, seg_o, dp_o);
endinterface

// File: rtl/bcd_display_scanner_seg.sv
// bcd_to_7seg: nibble to active-high {g..a} pattern, A-F shown as "E"
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  // lookup of the standard decimal patterns
  always_comb begin
    seg_o = SEG_E;
    case (nib_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_E;
    endcase
  end
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: multiplexed 4-digit 7-segment driver with zero blanking and flag flashing
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 100000,
  parameter int BLINK_SCANS    = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic clk,
  input logic clr_n,
  bcd_display_scanner_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_SCANS + 1);
  logic [PW-1:0] prescaler_q, prescaler_d;
  digit_idx_t    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic          of_q, of_d, uf_q, uf_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;
  logic [3:0]    an_q, an_d, an_hi;
  logic [6:0]    seg_q, seg_d, seg_hi, dec;
  logic          dp_q, dp_d, dp_hi;
  logic          tick, wrap, bend, blank;
  logic [3:0]    nib;
  bcd_to_7seg u_dec (.nib_i(nib), .seg_o(dec));
  // scan timing, snapshot, blink and flag next state plus the registered pin image
  always_comb begin
    tick        = prescaler_q == PW'(REFRESH_DIV - 1);
    wrap        = tick && idx_q == 2'd3;
    bend        = bcnt_q == BW'(BLINK_SCANS - 1);
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    idx_d       = tick ? idx_q + 2'd1 : idx_q;
    snap_d      = wrap ? bus.value_i : snap_q;
    bcnt_d      = wrap ? (bend ? '0 : bcnt_q + 1'b1) : bcnt_q;
    blink_d     = blink_q ^ (wrap && bend);
    of_d        = bus.of_i | (of_q & ~bus.flag_ack_i);
    uf_d        = bus.uf_i | (uf_q & ~bus.flag_ack_i);
    nib         = snap_q[{idx_q, 2'b00} +: 4];
    blank       = bus.blank_lz_i && idx_q != 2'd0 && (snap_q >> {idx_q, 2'b00}) == 16'h0;
    seg_hi      = blank ? SEG_OFF : dec;
    an_hi       = (bus.en_i && !((of_q | uf_q) && blink_q)) ? 4'b0001 << idx_q : 4'b0000;
    dp_hi       = (of_q && idx_q == 2'd3) || (uf_q && idx_q == 2'd0);
    an_d        = AN_ACTIVE_LOW ? ~an_hi : an_hi;
    seg_d       = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    dp_d        = SEG_ACTIVE_LOW ? ~dp_hi : dp_hi;
  end
  // state and output registers; reset parks the pins inactive
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      prescaler_q <= '0;
      idx_q       <= '0;
      snap_q      <= '0;
      of_q        <= 1'b0;
      uf_q        <= 1'b0;
      bcnt_q      <= '0;
      blink_q     <= 1'b0;
      an_q        <= AN_ACTIVE_LOW ? 4'hF : 4'h0;
      seg_q       <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
      dp_q        <= SEG_ACTIVE_LOW;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      of_q        <= of_d;
      uf_q        <= uf_d;
      bcnt_q      <= bcnt_d;
      blink_q     <= blink_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end
  assign bus.an_o  = an_q;
  assign bus.seg_o = seg_q;
  assign bus.dp_o  = dp_q;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed scan-slot scoreboard for the display scanner
module tb_bcd_display_scanner;
  typedef struct {
    int         slot;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      name;
  } exp_t;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  bcd_display_scanner_if bus();
  bcd_display_scanner #(.REFRESH_DIV(4), .BLINK_SCANS(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
    dut (.clk(clk), .clr_n(clr_n), .bus(bus.slave));
  always #5 clk = ~clk;
  // cycles since reset release; pins of slot j are stable for cyc in 4j+1..4j+4
  always @(posedge clk) cyc <= !clr_n ? 0 : cyc + 1;
  task automatic chk(input string name, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    checks++;
    if ({bus.an_o, bus.seg_o, bus.dp_o} !== {an, seg, dp}) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
               name, bus.an_o, bus.seg_o, bus.dp_o, an, seg, dp);
    end
  endtask
  task automatic push(input int slot, input logic [3:0] an, input logic [6:0] seg_hi, input logic dp, input string name);
    exp_t e;
    e.slot = slot; e.an = an; e.seg = ~seg_hi; e.dp = dp; e.name = name;
    q.push_back(e);
  endtask
  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc != n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != n) begin
      errors++;
      $display("FAIL wait_cyc: got cyc=%0d, want %0d", cyc, n);
    end
  endtask
  // monitor: mid-slot sample, compare against every expectation due for this slot
  always @(negedge clk) begin
    if (clr_n && cyc % 4 == 2) begin
      int cur;
      cur = (cyc - 2) / 4;
      while (q.size() > 0 && q[0].slot <= cur) begin
        exp_t e;
        e = q.pop_front();
        if (e.slot < cur) begin
          checks++;
          errors++;
          $display("FAIL %s: slot %0d not sampled, now at slot %0d", e.name, e.slot, cur);
        end else chk(e.name, e.an, e.seg, e.dp);
      end
    end
  end
  initial begin
    bus.value_i = 16'h1234; bus.of_i = 0; bus.uf_i = 0; bus.flag_ack_i = 0;
    bus.en_i = 1; bus.blank_lz_i = 0;
    repeat (3) @(negedge clk);
    chk("reset_pins", 4'hF, 7'h7F, 1'b1);
    clr_n = 1'b1;
    push(4, 4'hE, 7'h66, 1, "scan1_d0_4");
    push(5, 4'hD, 7'h4F, 1, "scan1_d1_3");
    push(6, 4'hB, 7'h5B, 1, "scan1_d2_2");
    push(7, 4'h7, 7'h06, 1, "scan1_d3_1");
    wait_cyc(22); bus.value_i = 16'h5678;
    push(8, 4'hE, 7'h7F, 1, "tear_d0_8");
    push(9, 4'hD, 7'h07, 1, "tear_d1_7");
    push(10, 4'hB, 7'h7D, 1, "tear_d2_6");
    push(11, 4'h7, 7'h6D, 1, "tear_d3_5");
    wait_cyc(40); bus.value_i = 16'h0007; bus.blank_lz_i = 1;
    push(12, 4'hE, 7'h07, 1, "lz7_d0");
    push(13, 4'hD, 7'h00, 1, "lz7_d1_blank");
    push(15, 4'h7, 7'h00, 1, "lz7_d3_blank");
    wait_cyc(56); bus.value_i = 16'h0000;
    push(16, 4'hE, 7'h3F, 1, "lz0_d0_zero");
    push(17, 4'hD, 7'h00, 1, "lz0_d1_blank");
    wait_cyc(72); bus.value_i = 16'h00A9;
    push(20, 4'hE, 7'h6F, 1, "a9_d0_9");
    push(21, 4'hD, 7'h79, 1, "a9_d1_E");
    push(22, 4'hB, 7'h00, 1, "a9_d2_blank");
    push(23, 4'h7, 7'h00, 0, "of_dp_d3_early");
    wait_cyc(90); bus.of_i = 1;
    wait_cyc(91); bus.of_i = 0;
    push(24, 4'hF, 7'h6F, 1, "of_blink_d0");
    push(25, 4'hF, 7'h79, 1, "of_blink_d1");
    push(27, 4'hF, 7'h00, 0, "of_blink_d3_dp");
    push(28, 4'hF, 7'h6F, 1, "of_blink2_d0");
    push(32, 4'hE, 7'h6F, 1, "of_on_d0");
    push(35, 4'h7, 7'h00, 0, "of_on_d3_dp");
    push(36, 4'hE, 7'h6F, 1, "of_on2_d0");
    wait_cyc(150); bus.of_i = 1; bus.flag_ack_i = 1;
    wait_cyc(151); bus.of_i = 0; bus.flag_ack_i = 0;
    push(40, 4'hF, 7'h6F, 1, "of_ack_same_d0");
    push(41, 4'hF, 7'h79, 1, "of_ack_same_d1");
    wait_cyc(170); bus.flag_ack_i = 1;
    wait_cyc(171); bus.flag_ack_i = 0;
    push(43, 4'h7, 7'h00, 1, "ack_d3");
    push(44, 4'hE, 7'h6F, 1, "ack_d0");
    wait_cyc(185); bus.uf_i = 1;
    wait_cyc(186); bus.uf_i = 0;
    push(48, 4'hE, 7'h6F, 0, "uf_on_d0_dp");
    push(51, 4'h7, 7'h00, 1, "uf_on_d3");
    push(56, 4'hF, 7'h6F, 0, "uf_blink_d0_dp");
    wait_cyc(230); bus.flag_ack_i = 1;
    wait_cyc(231); bus.flag_ack_i = 0;
    push(59, 4'h7, 7'h00, 1, "uf_ack_d3");
    wait_cyc(245); bus.en_i = 0;
    push(62, 4'hF, 7'h00, 1, "en_off_d2");
    push(63, 4'hF, 7'h00, 1, "en_off_d3");
    wait_cyc(258); bus.en_i = 1;
    push(65, 4'hD, 7'h79, 1, "en_on_d1");
    wait_cyc(270); bus.of_i = 1;
    wait_cyc(271); bus.of_i = 0;
    push(68, 4'hE, 7'h6F, 1, "pre_rst_d0");
    push(69, 4'hD, 7'h79, 1, "pre_rst_d1");
    wait_cyc(282); clr_n = 1'b0;
    @(negedge clk);
    chk("midscan_reset_pins", 4'hF, 7'h7F, 1'b1);
    push(0, 4'hE, 7'h3F, 1, "post_rst_d0");
    push(1, 4'hD, 7'h00, 1, "post_rst_d1");
    push(3, 4'h7, 7'h00, 1, "post_rst_d3_noflag");
    clr_n = 1'b1;
    wait_cyc(20);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
